// File: rtl/br_flag_unit_pkg.sv
// Shared encodings for the branch/flag unit: condition codes and FSM states.
package br_flag_unit_pkg;

  typedef enum logic [2:0] {
    NEQ    = 3'd0,
    EQ     = 3'd1,
    GT     = 3'd2,
    LT     = 3'd3,
    GTE    = 3'd4,
    LTE    = 3'd5,
    OVFL   = 3'd6,
    UNCOND = 3'd7
  } br_cond_e;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_e;

endpackage

// File: rtl/br_flag_unit_cond_eval.sv
// Combinational branch-condition evaluator over the architectural Z/V/N flags.
module br_cond_eval
  import br_flag_unit_pkg::*;
(
  input  logic       z,
  input  logic       v,
  input  logic       n,
  input  logic [2:0] br_cond,
  output logic       cond_true
);

  always_comb begin
    cond_true = 1'b0;
    case (br_cond_e'(br_cond))
      NEQ:     cond_true = !z;
      EQ:      cond_true = z;
      GT:      cond_true = !z && !n;
      LT:      cond_true = n;
      GTE:     cond_true = z || !n;
      LTE:     cond_true = n || z;
      OVFL:    cond_true = v;
      UNCOND:  cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/br_flag_unit.sv
// EX-stage flag register, branch resolution, PC redirect and wrong-path flush
// sequencing, plus a saturating count of taken control transfers.
module br_flag_unit
  import br_flag_unit_pkg::*;
#(
  parameter int ADDR_W    = 17,
  parameter int FLUSH_CYC = 2,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              zr,
  input  logic              ov,
  input  logic              neg,
  input  logic              upd_z,
  input  logic              upd_nv,
  input  logic              br_instr,
  input  logic              jmp_instr,
  input  logic [2:0]        br_cond,
  input  logic [ADDR_W-1:0] tgt,
  output logic              pc_sel,
  output logic [ADDR_W-1:0] pc_tgt,
  output logic              flush,
  output logic              z_flag,
  output logic              v_flag,
  output logic              n_flag,
  output logic [CNT_W-1:0]  taken_cnt
);

  localparam logic [2:0] FCNT_INIT = 3'(FLUSH_CYC - 1);

  state_e              r_state;
  state_e              w_state_nxt;
  logic [2:0]          r_fcnt;
  logic                r_pc_sel;
  logic [ADDR_W-1:0]   r_pc_tgt;
  logic                r_flush;
  logic                r_z;
  logic                r_v;
  logic                r_n;
  logic [CNT_W-1:0]    r_cnt;
  logic                w_cond_true;
  logic                w_take;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  // Conditions see the flags left by the previous EX instruction.
  br_cond_eval u_cond_eval (
    .z         (r_z),
    .v         (r_v),
    .n         (r_n),
    .br_cond   (br_cond),
    .cond_true (w_cond_true)
  );

  assign w_take = (jmp_instr || (br_instr && w_cond_true)) && !stall && (r_state == IDLE);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_take) w_state_nxt = FLUSH;
      FLUSH:   if (!stall && (r_fcnt == 3'd0)) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fcnt   <= 3'd0;
      r_pc_sel <= 1'b0;
      r_pc_tgt <= '0;
      r_flush  <= 1'b0;
      r_z      <= 1'b0;
      r_v      <= 1'b0;
      r_n      <= 1'b0;
      r_cnt    <= '0;
    end else if (!stall) begin
      // Instructions being squashed must not touch architectural flags.
      if (!r_flush) begin
        if (upd_z) r_z <= zr;
        if (upd_nv) begin
          r_v <= ov;
          r_n <= neg;
        end
      end
      case (r_state)
        IDLE: begin
          if (w_take) begin
            r_pc_sel <= 1'b1;
            r_pc_tgt <= tgt;
            r_flush  <= 1'b1;
            r_fcnt   <= FCNT_INIT;
            r_cnt    <= sat_inc(r_cnt);
          end
        end
        FLUSH: begin
          r_pc_sel <= 1'b0;
          if (r_fcnt == 3'd0) r_flush <= 1'b0;
          else                r_fcnt  <= r_fcnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign pc_sel    = r_pc_sel;
  assign pc_tgt    = r_pc_tgt;
  assign flush     = r_flush;
  assign z_flag    = r_z;
  assign v_flag    = r_v;
  assign n_flag    = r_n;
  assign taken_cnt = r_cnt;

endmodule

// File: tb/tb_br_flag_unit.sv
// Self-checking bench for br_flag_unit: directed scenarios plus random traffic
// compared every cycle against a behavioural model.
module tb_br_flag_unit;

  localparam int ADDR_W    = 17;
  localparam int FLUSH_CYC = 2;
  localparam int CNT_W     = 4;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              stall, zr, ov, neg, upd_z, upd_nv, br_instr, jmp_instr;
  logic [2:0]        br_cond;
  logic [ADDR_W-1:0] tgt;
  logic              pc_sel, flush, z_flag, v_flag, n_flag;
  logic [ADDR_W-1:0] pc_tgt;
  logic [CNT_W-1:0]  taken_cnt;

  br_flag_unit #(.ADDR_W(ADDR_W), .FLUSH_CYC(FLUSH_CYC), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .zr(zr), .ov(ov), .neg(neg),
    .upd_z(upd_z), .upd_nv(upd_nv), .br_instr(br_instr), .jmp_instr(jmp_instr),
    .br_cond(br_cond), .tgt(tgt), .pc_sel(pc_sel), .pc_tgt(pc_tgt), .flush(flush),
    .z_flag(z_flag), .v_flag(v_flag), .n_flag(n_flag), .taken_cnt(taken_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: flags, remaining flush cycles, pending redirect, count.
  logic              m_z, m_v, m_n, m_pc_sel;
  logic [ADDR_W-1:0] m_tgt;
  int                m_left;
  int                m_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic cond_ok(input logic [2:0] c, input logic z, input logic v, input logic n);
    case (c)
      3'd0: return !z;
      3'd1: return z;
      3'd2: return !z && !n;
      3'd3: return n;
      3'd4: return z || !n;
      3'd5: return n || z;
      3'd6: return v;
      default: return 1'b1;
    endcase
  endfunction

  task automatic model_reset();
    m_z = 0; m_v = 0; m_n = 0; m_pc_sel = 0; m_tgt = '0; m_left = 0; m_cnt = 0;
  endtask

  task automatic model_edge();
    logic take;
    if (stall) return;
    if (m_left == 0) begin
      take = jmp_instr || (br_instr && cond_ok(br_cond, m_z, m_v, m_n));
      if (upd_z) m_z = zr;
      if (upd_nv) begin m_v = ov; m_n = neg; end
      if (take) begin
        m_pc_sel = 1'b1;
        m_tgt    = tgt;
        m_left   = FLUSH_CYC;
        if (m_cnt < CNT_MAX) m_cnt++;
      end
    end else begin
      m_pc_sel = 1'b0;
      m_left--;
    end
  endtask

  task automatic compare_all(input string ph);
    check({ph, ".pc_sel"},    32'(pc_sel),    32'(m_pc_sel));
    check({ph, ".pc_tgt"},    32'(pc_tgt),    32'(m_tgt));
    check({ph, ".flush"},     32'(flush),     32'(m_left > 0));
    check({ph, ".z_flag"},    32'(z_flag),    32'(m_z));
    check({ph, ".v_flag"},    32'(v_flag),    32'(m_v));
    check({ph, ".n_flag"},    32'(n_flag),    32'(m_n));
    check({ph, ".taken_cnt"}, 32'(taken_cnt), 32'(m_cnt));
  endtask

  task automatic step(input string ph);
    model_edge();
    @(posedge clk);
    #1;
    compare_all(ph);
  endtask

  task automatic quiet();
    stall = 0; upd_z = 0; upd_nv = 0; br_instr = 0; jmp_instr = 0;
    zr = 0; ov = 0; neg = 0; br_cond = 3'd0;
  endtask

  task automatic set_flags(input logic z, input logic v, input logic n);
    quiet(); upd_z = 1; upd_nv = 1; zr = z; ov = v; neg = n;
    step("setf");
  endtask

  task automatic async_reset(input string ph);
    #3;
    rst_n = 0;
    #1;
    model_reset();
    compare_all(ph);
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  initial begin
    quiet(); tgt = '0; rst_n = 0; model_reset();
    @(posedge clk); #1;
    compare_all("reset");
    rst_n = 1;
    for (int i = 0; i < 5; i++) step("post_reset");

    // Flag masking
    quiet(); upd_z = 1; zr = 1; ov = 1; neg = 1;
    step("mask_z");
    check("mask.z", 32'(z_flag), 32'd1);
    check("mask.v", 32'(v_flag), 32'd0);
    check("mask.n", 32'(n_flag), 32'd0);
    quiet(); upd_nv = 1; neg = 1;
    step("mask_nv");
    check("mask.n2", 32'(n_flag), 32'd1);
    check("mask.z2", 32'(z_flag), 32'd1);

    // Example LT branch
    set_flags(0, 0, 1);
    quiet(); br_instr = 1; br_cond = 3'd3; tgt = 17'h00123;
    step("lt_take");
    check("lt.pc_sel", 32'(pc_sel), 32'd1);
    check("lt.pc_tgt", 32'(pc_tgt), 32'h123);
    check("lt.flush",  32'(flush),  32'd1);
    check("lt.cnt",    32'(taken_cnt), 32'd1);
    quiet();
    step("lt_f1");
    check("lt.flush1",  32'(flush),  32'd1);
    check("lt.pc_sel1", 32'(pc_sel), 32'd0);
    step("lt_f2");
    check("lt.flush2",  32'(flush),  32'd0);

    // Full condition table
    for (int c = 0; c < 8; c++) begin
      for (int f = 0; f < 8; f++) begin
        set_flags(f[2], f[1], f[0]);
        quiet(); br_instr = 1; br_cond = 3'(c); tgt = ADDR_W'($urandom);
        step("cond_tab");
        quiet();
        step("cond_f1");
        step("cond_f2");
      end
    end

    // Wrong-path squash
    async_reset("rst_squash");
    set_flags(0, 0, 0);
    quiet(); jmp_instr = 1; tgt = 17'h1abcd;
    step("sq_take");
    quiet(); br_instr = 1; br_cond = 3'd7; upd_z = 1; zr = 1; tgt = 17'h00055;
    step("sq_f1");
    step("sq_f2");
    quiet();
    step("sq_idle");
    check("squash.z",   32'(z_flag),    32'd0);
    check("squash.cnt", 32'(taken_cnt), 32'd1);
    check("squash.tgt", 32'(pc_tgt),    32'h1abcd);

    // Stall behaviour
    quiet(); jmp_instr = 1; stall = 1; tgt = 17'h00777;
    step("st_blocked");
    check("stall.no_redirect", 32'(pc_sel), 32'd0);
    stall = 0;
    step("st_take");
    quiet(); stall = 1;
    for (int i = 0; i < 3; i++) begin
      step("st_hold");
      check("stall.pc_held", 32'(pc_sel), 32'd1);
      check("stall.flush",   32'(flush),  32'd1);
    end
    stall = 0;
    step("st_r1");
    check("stall.flush4", 32'(flush), 32'd1);
    step("st_r2");
    check("stall.flush5", 32'(flush), 32'd0);

    // Saturation
    async_reset("rst_sat");
    for (int j = 0; j < 20; j++) begin
      quiet(); jmp_instr = 1; tgt = ADDR_W'(j);
      step("sat_take");
      quiet();
      step("sat_f1");
      step("sat_f2");
    end
    check("sat.cnt", 32'(taken_cnt), 32'hF);

    // Asynchronous reset in the middle of a flush
    quiet(); jmp_instr = 1; tgt = 17'h0beef;
    step("rf_take");
    quiet();
    async_reset("rst_flush");
    check("rflush.flush", 32'(flush),     32'd0);
    check("rflush.cnt",   32'(taken_cnt), 32'd0);
    for (int i = 0; i < 5; i++) step("rf_quiet");

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      stall     = ($urandom_range(0, 7) == 0);
      br_instr  = ($urandom_range(0, 2) == 0);
      jmp_instr = ($urandom_range(0, 6) == 0);
      upd_z     = 1'($urandom_range(0, 1));
      upd_nv    = 1'($urandom_range(0, 1));
      zr        = 1'($urandom_range(0, 1));
      ov        = 1'($urandom_range(0, 1));
      neg       = 1'($urandom_range(0, 1));
      br_cond   = 3'($urandom);
      tgt       = ADDR_W'($urandom);
      step("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/br_flag_unit.md
Name: br_flag_unit

Overview:
- Sits directly downstream of the EX-stage ALU and consumes its ov/zr/neg flags and its unflopped ID/EX result, used as the branch/jump target.
- Holds the architectural Z/V/N flag register with per-instruction update enables.
- Evaluates branch conditions, then issues a registered PC redirect and a multi-cycle flush of wrong-path instructions.
- Keeps a saturating count of taken control transfers for debug.

Parameters:
ADDR_W, 17, width of branch target / PC
FLUSH_CYC, 2, cycles flush is held after a taken transfer (1..7)
CNT_W, 16, width of taken-transfer counter

Ports:
clk  in  1  system clock
rst_n  in  1  reset
stall  in  1  global pipeline stall; freezes all state
zr  in  1  ALU zero flag (EX)
ov  in  1  ALU overflow flag (EX)
neg  in  1  ALU negative flag (EX)
upd_z  in  1  EX instr updates Z
upd_nv  in  1  EX instr updates N and V
br_instr  in  1  conditional branch in EX
jmp_instr  in  1  unconditional jump/jr in EX
br_cond  in  3  branch condition code
tgt  in  ADDR_W  target address from ALU dst
pc_sel  out  1  select pc_tgt as next PC (one cycle)
pc_tgt  out  ADDR_W  redirect address
flush  out  1  squash IF/ID and ID/EX
z_flag, v_flag, n_flag  out  1 each  flag register
taken_cnt  out  CNT_W  taken-transfer count

Behaviour:
- One clock. Reset is asynchronous and active-low: clk, rst_n.
- Reset state: all outputs 0, FSM in IDLE, flush counter 0.
- Flag register:
  - On posedge with !stall && !flush: if upd_z, z_flag<=zr; if upd_nv, v_flag<=ov and n_flag<=neg.
  - Flags are otherwise held. Wrong-path instructions (flush=1) never update flags.
- Condition evaluation is combinational on the registered flags, i.e. those of the previous EX instruction:
  - 000 NEQ: !Z
  - 001 EQ: Z
  - 010 GT: !Z & !N
  - 011 LT: N
  - 100 GTE: Z | !N
  - 101 LTE: N | Z
  - 110 OVFL: V
  - 111 UNCOND: 1
- take = (jmp_instr | (br_instr & cond_true)) & !stall & state==IDLE.
- jmp_instr and br_instr both set: treat as jump.
- FSM states IDLE and FLUSH:
  - IDLE, take=1 -> FLUSH. Registered at that edge: pc_sel<=1, pc_tgt<=tgt, flush<=1, fcnt<=FLUSH_CYC-1, taken_cnt increments (saturating at all-ones).
  - FLUSH: pc_sel<=0 after exactly one cycle. pc_sel is held high while stall=1, so the redirect is not lost.
  - FLUSH, !stall: if fcnt==0 -> IDLE with flush<=0; else fcnt decrements.
  - FLUSH, stall=1: everything frozen.
  - br_instr/jmp_instr are ignored in FLUSH; back-to-back transfers are impossible by construction.
- Latency:
  - take in cycle N -> pc_sel and flush high in cycle N+1.
  - flush stays high FLUSH_CYC cycles, counting only non-stalled cycles.
- Flag update and take in the same cycle:
  - Evaluation uses the pre-update flags.
  - The update still occurs, since that branch/ALU instruction is on the correct path.
- rst_n asserted mid-FLUSH: immediate return to IDLE, all outputs 0 without waiting for clk; taken_cnt cleared.
- taken_cnt wraps never; holds at 2^CNT_W-1.

Decomposition:
- Shared package/include (alongside common_params.inc): br_cond encodings (NEQ, EQ, GT, LT, GTE, LTE, OVFL, UNCOND) and FSM state constants IDLE/FLUSH.
- One sub-module, br_cond_eval: purely combinational; inputs z, v, n, br_cond; output cond_true.
- FSM, flag register and counter stay in br_flag_unit.

Test Plan:
- Reset: rst_n=0 mid-run -> all outputs 0 asynchronously; release, no br/jmp for 5 cycles -> outputs stay 0.
- Flag masking: upd_z=1, upd_nv=0, zr=1, ov=1, neg=1 -> z_flag=1, v_flag=0, n_flag=0 next cycle. Then upd_nv=1 with neg=1 -> n_flag=1, z_flag unchanged.
- Condition table: for all 8 br_cond × 8 flag combos, br_instr=1 -> pc_sel matches table. Example: Z=0, N=1, cond LT, tgt=17'h00123 -> next cycle pc_sel=1, pc_tgt=17'h00123, flush=1 for 2 cycles, taken_cnt=1.
- Wrong-path squash: during FLUSH drive br_instr=1, cond UNCOND, upd_z=1, zr=1 -> no second pc_sel, z_flag unchanged, taken_cnt unchanged.
- Stall: jmp_instr=1 with stall=1 -> no redirect. Stall asserted in the first FLUSH cycle for 3 cycles -> pc_sel held, flush high for 3+2 cycles total.
- Saturation/reset: CNT_W=4, 20 taken jumps -> taken_cnt=4'hF. rst_n low during flush -> flush=0, taken_cnt=0.
